multicycle_datapath: RTL and testbench

Multi-cycle RV32I-subset datapath: successor to the single-cycle datapath, parametrised in word width and reset vector. It drives external instruction and data memories through request/acknowledge handshakes, so memories may take any number of wait cycles. The block sequences each instruction through an explicit state machine. It reuses the existing register file, ALU, ALU control and immediate generator.

---
 rtl/riscv_pkg.sv | 74 +++++++
 rtl/alu.sv | 47 ++++
 rtl/alu_control.sv | 42 ++++
 rtl/imm_generator.sv | 35 +++
 rtl/mc_control.sv | 151 +++++++++++++++
 rtl/register_file.sv | 39 +++
 rtl/multicycle_datapath.sv | 164 ++++++++++++++++
 tb/tb_multicycle_datapath.sv | 261 ++++++++++++++++++++++++++
 8 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared encodings for the multi-cycle RV32I-subset datapath:
//          opcodes, FSM states, ALUOp / ALU function codes, reset vector
//          default and the instruction legality check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_fn_t;

  // Only the supported subset is legal; funct7 is checked where it selects an op.
  function automatic logic is_legal(input logic [31:0] ir);
    logic [6:0] f7;
    logic [2:0] f3;
    logic       legal;
    f7    = ir[31:25];
    f3    = ir[14:12];
    legal = 1'b0;
    case (ir[6:0])
      OP_RTYPE:  legal = (f7 == 7'h00) ||
                         ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OP_ITYPE: begin
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
      end
      OP_LOAD:   legal = (f3 == 3'b010);
      OP_STORE:  legal = (f3 == 3'b010);
      OP_BRANCH: legal = (f3 == 3'b000);
      default:   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu
// Brief  : Integer ALU for the RV32I register/immediate operations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
  import riscv_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  alu_fn_t              i_fn,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_zero
);

  localparam int SHW = $clog2(WORD_SIZE);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // Operation select.
  always_comb begin
    o_result = '0;
    case (i_fn)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = {{(WORD_SIZE-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(WORD_SIZE-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = WORD_SIZE'($signed(i_a) >>> w_shamt);
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_control.sv
// ============================================================================
// Module : alu_control
// Brief  : Maps ALUOp plus funct3/funct7 to an ALU function code.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_control
  import riscv_pkg::*;
(
  input  aluop_t     i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_is_rtype,
  output alu_fn_t    o_fn
);

  // Fixed add/sub for address and compare, otherwise funct-decoded.
  // funct7[5] means SUB only for R-type; ADDI uses that bit as immediate.
  always_comb begin
    o_fn = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_fn = ALU_ADD;
      ALUOP_SUB: o_fn = ALU_SUB;
      default: begin
        case (i_funct3)
          3'b000:  o_fn = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_fn = ALU_SLL;
          3'b010:  o_fn = ALU_SLT;
          3'b011:  o_fn = ALU_SLTU;
          3'b100:  o_fn = ALU_XOR;
          3'b101:  o_fn = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_fn = ALU_OR;
          default: o_fn = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_generator.sv
// ============================================================================
// Module : imm_generator
// Brief  : Sign-extended immediate for I, S and B formats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_generator
  import riscv_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [31:0]          i_ir,
  output logic [WORD_SIZE-1:0] o_imm
);

  // Immediate format chosen by opcode.
  always_comb begin
    o_imm = '0;
    case (i_ir[6:0])
      OP_ITYPE, OP_LOAD:
        o_imm = {{(WORD_SIZE-12){i_ir[31]}}, i_ir[31:20]};
      OP_STORE:
        o_imm = {{(WORD_SIZE-12){i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OP_BRANCH:
        o_imm = {{(WORD_SIZE-13){i_ir[31]}}, i_ir[31], i_ir[7],
                 i_ir[30:25], i_ir[11:8], 1'b0};
      default:
        o_imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// Module : mc_control
// Brief  : Instruction sequencer FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) for the
//          multi-cycle datapath: latch enables, ALU control, PC update,
//          memory requests, retire and halt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control
  import riscv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_legal,
  input  logic       i_alu_zero,
  input  logic       i_pc_misaligned,
  input  logic       i_addr_misaligned,
  input  logic       i_imem_ack,
  input  logic       i_dmem_ack,
  output aluop_t     o_alu_op,
  output logic       o_alu_src_imm,
  output logic       o_ir_en,
  output logic       o_ab_en,
  output logic       o_aluout_en,
  output logic       o_mdr_en,
  output logic       o_pc_en,
  output logic       o_pc_branch,
  output logic       o_rf_we,
  output logic       o_wb_mem,
  output logic       o_imem_req,
  output logic       o_dmem_req,
  output logic       o_dmem_wen,
  output logic       o_retire,
  output logic       o_halt
);

  state_t r_state;
  state_t w_next;
  logic   r_started;

  // State register; r_started holds off the first fetch until the first
  // clock after reset release so requests are low throughout reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_FETCH;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    w_next        = r_state;
    o_alu_op      = ALUOP_ADD;
    o_alu_src_imm = 1'b0;
    o_ir_en       = 1'b0;
    o_ab_en       = 1'b0;
    o_aluout_en   = 1'b0;
    o_mdr_en      = 1'b0;
    o_pc_en       = 1'b0;
    o_pc_branch   = 1'b0;
    o_rf_we       = 1'b0;
    o_wb_mem      = 1'b0;
    o_imem_req    = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_wen    = 1'b0;
    o_retire      = 1'b0;
    o_halt        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (r_started) begin
          if (i_pc_misaligned) begin
            w_next = ST_TRAP;
          end else begin
            o_imem_req = 1'b1;
            if (i_imem_ack) begin
              o_ir_en = 1'b1;
              w_next  = ST_DECODE;
            end
          end
        end
      end
      ST_DECODE: begin
        o_ab_en = 1'b1;
        w_next  = i_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        o_aluout_en = 1'b1;
        case (i_opcode)
          OP_RTYPE: begin
            o_alu_op = ALUOP_FUNCT;
            w_next   = ST_WB;
          end
          OP_ITYPE: begin
            o_alu_op      = ALUOP_FUNCT;
            o_alu_src_imm = 1'b1;
            w_next        = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            o_alu_src_imm = 1'b1;
            w_next        = ST_MEM;
          end
          OP_BRANCH: begin
            o_alu_op    = ALUOP_SUB;
            o_pc_en     = 1'b1;
            o_pc_branch = i_alu_zero;
            o_retire    = 1'b1;
            w_next      = ST_FETCH;
          end
          default: w_next = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (i_addr_misaligned) begin
          w_next = ST_TRAP;
        end else begin
          o_dmem_req = 1'b1;
          o_dmem_wen = (i_opcode == OP_STORE);
          if (i_dmem_ack) begin
            if (i_opcode == OP_STORE) begin
              o_pc_en  = 1'b1;
              o_retire = 1'b1;
              w_next   = ST_FETCH;
            end else begin
              o_mdr_en = 1'b1;
              w_next   = ST_WB;
            end
          end
        end
      end
      ST_WB: begin
        o_rf_we  = 1'b1;
        o_wb_mem = (i_opcode == OP_LOAD);
        o_pc_en  = 1'b1;
        o_retire = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_TRAP: begin
        o_halt = 1'b1;
      end
      default: w_next = ST_TRAP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module : register_file
// Brief  : 32-entry register file, two asynchronous read ports, one write
//          port; x0 reads as zero and ignores writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [4:0]           i_waddr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic [4:0]           i_raddr1,
  input  logic [4:0]           i_raddr2,
  output logic [WORD_SIZE-1:0] o_rdata1,
  output logic [WORD_SIZE-1:0] o_rdata2
);

  logic [WORD_SIZE-1:0] r_regs [0:31];

  // Register storage; clears on reset, x0 is never written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/multicycle_datapath.sv
// ============================================================================
// Module : multicycle_datapath
// Brief  : Multi-cycle RV32I-subset datapath with handshaked instruction and
//          data memory ports. Holds PC/IR/A/B/IMM/ALUOUT/MDR; sequencing is in
//          mc_control. Define PERF_CNT_EN to add 64-bit cycle and
//          retired-instruction counters (o_cycle_cnt, o_instret_cnt).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_datapath
  import riscv_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEFAULT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_imem_req,
  output logic [WORD_SIZE-1:0] o_imem_addr,
  input  logic [31:0]          i_imem_rdata,
  input  logic                 i_imem_ack,
  output logic                 o_dmem_req,
  output logic                 o_dmem_wen,
  output logic [WORD_SIZE-1:0] o_dmem_addr,
  output logic [WORD_SIZE-1:0] o_dmem_wdata,
  input  logic [WORD_SIZE-1:0] i_dmem_rdata,
  input  logic                 i_dmem_ack,
  output logic                 o_retire,
  output logic                 o_halt,
  output logic [WORD_SIZE-1:0] o_pc
`ifdef PERF_CNT_EN
  ,
  output logic [63:0]          o_cycle_cnt,
  output logic [63:0]          o_instret_cnt
`endif
);

  logic [WORD_SIZE-1:0] r_pc, r_a, r_b, r_imm, r_aluout, r_mdr;
  logic [31:0]          r_ir;

  logic [WORD_SIZE-1:0] w_rs1_data, w_rs2_data, w_imm, w_alu_b, w_alu_result;
  logic [WORD_SIZE-1:0] w_wb_data, w_pc_plus4, w_pc_target;
  logic                 w_alu_zero;
  aluop_t               w_alu_op;
  alu_fn_t              w_alu_fn;
  logic w_alu_src_imm, w_ir_en, w_ab_en, w_aluout_en, w_mdr_en;
  logic w_pc_en, w_pc_branch, w_rf_we, w_wb_mem;

  mc_control u_control (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_opcode          (r_ir[6:0]),
    .i_legal           (is_legal(r_ir)),
    .i_alu_zero        (w_alu_zero),
    .i_pc_misaligned   (r_pc[1:0] != 2'b00),
    .i_addr_misaligned (r_aluout[1:0] != 2'b00),
    .i_imem_ack        (i_imem_ack),
    .i_dmem_ack        (i_dmem_ack),
    .o_alu_op          (w_alu_op),
    .o_alu_src_imm     (w_alu_src_imm),
    .o_ir_en           (w_ir_en),
    .o_ab_en           (w_ab_en),
    .o_aluout_en       (w_aluout_en),
    .o_mdr_en          (w_mdr_en),
    .o_pc_en           (w_pc_en),
    .o_pc_branch       (w_pc_branch),
    .o_rf_we           (w_rf_we),
    .o_wb_mem          (w_wb_mem),
    .o_imem_req        (o_imem_req),
    .o_dmem_req        (o_dmem_req),
    .o_dmem_wen        (o_dmem_wen),
    .o_retire          (o_retire),
    .o_halt            (o_halt)
  );

  register_file #(.WORD_SIZE(WORD_SIZE)) u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (w_rf_we),
    .i_waddr  (r_ir[11:7]),
    .i_wdata  (w_wb_data),
    .i_raddr1 (r_ir[19:15]),
    .i_raddr2 (r_ir[24:20]),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  imm_generator #(.WORD_SIZE(WORD_SIZE)) u_immgen (
    .i_ir  (r_ir),
    .o_imm (w_imm)
  );

  alu_control u_alu_ctrl (
    .i_alu_op   (w_alu_op),
    .i_funct3   (r_ir[14:12]),
    .i_funct7b5 (r_ir[30]),
    .i_is_rtype (r_ir[5]),
    .o_fn       (w_alu_fn)
  );

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .i_fn     (w_alu_fn),
    .i_a      (r_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign w_alu_b     = w_alu_src_imm ? r_imm : r_b;
  assign w_wb_data   = w_wb_mem ? r_mdr : r_aluout;
  assign w_pc_plus4  = r_pc + WORD_SIZE'(4);
  assign w_pc_target = r_pc + r_imm;

  // Architectural latches; each loads only in the state that enables it,
  // so address/data presented to memory stay stable across wait cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      if (w_ir_en)     r_ir     <= i_imem_rdata;
      if (w_ab_en) begin
        r_a   <= w_rs1_data;
        r_b   <= w_rs2_data;
        r_imm <= w_imm;
      end
      if (w_aluout_en) r_aluout <= w_alu_result;
      if (w_mdr_en)    r_mdr    <= i_dmem_rdata;
      if (w_pc_en)     r_pc     <= w_pc_branch ? w_pc_target : w_pc_plus4;
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_dmem_addr  = r_aluout;
  assign o_dmem_wdata = r_b;
  assign o_pc         = r_pc;

`ifdef PERF_CNT_EN
  logic [63:0] r_cycle_cnt, r_instret_cnt;

  // Cycle counter stops in TRAP; instret follows the retire pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (!o_halt)  r_cycle_cnt   <= r_cycle_cnt + 64'd1;
      if (o_retire) r_instret_cnt <= r_instret_cnt + 64'd1;
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
// ============================================================================
// Module : tb_multicycle_datapath
// Brief  : Directed self-checking bench for multicycle_datapath with
//          instruction/data memory responders of programmable wait.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_datapath;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, dmem_req, dmem_wen, dmem_ack, retire, halt;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;

  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:63];
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;

  int checks   = 0;
  int failures = 0;

  multicycle_datapath #(.WORD_SIZE(32), .RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_rdata (imem_rdata),
    .i_imem_ack   (imem_ack),
    .o_dmem_req   (dmem_req),
    .o_dmem_wen   (dmem_wen),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata),
    .i_dmem_ack   (dmem_ack),
    .o_retire     (retire),
    .o_halt       (halt),
    .o_pc         (pc)
  );

  initial forever #5 clk = ~clk;

  // Memory responders: ack after the programmed number of wait cycles.
  assign imem_ack   = imem_req && (icnt >= imem_wait);
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign imem_rdata = imem[imem_addr[8:2]];
  assign dmem_rdata = dmem[dmem_addr[7:2]];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_wen) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end

  // Monitor, sampled on the falling edge.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] len;
    logic        stable;
  } st_rec_t;

  logic [31:0] fetch_q [$];
  int          lat_q   [$];
  st_rec_t     st_q    [$];
  int          ncyc = 0, fstart = 0, n_dreq = 0, n_after_halt = 0, d_len = 0;
  logic        prev_ireq = 1'b0, d_act = 1'b0, d_stable = 1'b0, d_wen0 = 1'b0;
  logic [31:0] d_addr0 = '0, d_wd0 = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_ireq = 1'b0;
      d_act     = 1'b0;
    end else begin
      ncyc++;
      if (imem_req && !prev_ireq) fstart = ncyc;
      prev_ireq = imem_req;
      if (imem_req && imem_ack) fetch_q.push_back(imem_addr);
      if (retire) lat_q.push_back(ncyc - fstart + 1);
      if (dmem_req) begin
        n_dreq++;
        if (!d_act) begin
          d_addr0 = dmem_addr; d_wd0 = dmem_wdata; d_wen0 = dmem_wen;
          d_len = 0; d_stable = 1'b1;
        end else if (dmem_addr !== d_addr0 || dmem_wen !== d_wen0 ||
                     (d_wen0 && dmem_wdata !== d_wd0)) begin
          d_stable = 1'b0;
        end
        d_len++;
        d_act = 1'b1;
        if (dmem_ack) begin
          if (d_wen0) st_q.push_back('{d_addr0, d_wd0, 32'(d_len), d_stable});
          d_act = 1'b0;
        end
      end
      if (halt && (imem_req || dmem_req)) n_after_halt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_instr(input logic [31:0] addr, input logic [31:0] word);
    imem[addr[8:2]] = word;
  endtask

  // Expected run-1 trace (dmem wait 3, imem zero wait).
  logic [31:0] exp_fetch [14] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                                  32'h114, 32'h118, 32'h11C, 32'h020, 32'h018,
                                  32'h01C, 32'h028, 32'h02C, 32'h030};
  int          exp_lat   [13] = '{4, 4, 4, 7, 8, 7, 7, 3, 3, 3, 3, 4, 7};
  logic [31:0] exp_st_a  [4]  = '{32'd8, 32'd12, 32'd16, 32'd20};
  logic [31:0] exp_st_d  [4]  = '{32'd10, 32'd10, 32'd0, 32'd5};

  initial begin : stim
    int bf, bl, bd, bh;
    logic got;
    logic [31:0] obs;
    #200000;
  end

  initial begin
    int bf, bl, bd, bh;
    logic got;
    logic [31:0] obs;
    rst_n     = 1'b0;
    imem_wait = 0;
    dmem_wait = 3;
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++)  dmem[i] = 32'h0;
    load_instr(32'h100, 32'h00500093); // addi x1,x0,5
    load_instr(32'h104, 32'h00108133); // add  x2,x1,x1
    load_instr(32'h108, 32'h00700013); // addi x0,x0,7
    load_instr(32'h10C, 32'h00202423); // sw   x2,8(x0)
    load_instr(32'h110, 32'h00802183); // lw   x3,8(x0)
    load_instr(32'h114, 32'h00302623); // sw   x3,12(x0)
    load_instr(32'h118, 32'h00002823); // sw   x0,16(x0)
    load_instr(32'h11C, 32'hF00002E3); // beq  x0,x0,-252 -> 0x20
    load_instr(32'h020, 32'hFE108CE3); // beq  x1,x1,-8   -> 0x18
    load_instr(32'h018, 32'h00208463); // beq  x1,x2,8    not taken
    load_instr(32'h01C, 32'h00000663); // beq  x0,x0,12   -> 0x28
    load_instr(32'h028, 32'h40110233); // sub  x4,x2,x1
    load_instr(32'h02C, 32'h00402A23); // sw   x4,20(x0)
    load_instr(32'h030, 32'h0000007F); // illegal

    // ---- run 1: reset state, then the program ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_pc", pc, RST_PC);
    check("rst_halt", halt, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_wen", dmem_wen, 1'b0);
    check("rst_retire", retire, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_imem_req", imem_req, 1'b1);
    check("first_imem_addr", imem_addr, RST_PC);
    for (int i = 0; i < 400; i++) begin
      if (halt === 1'b1) break;
      @(posedge clk); #1;
    end
    check("run1_halt", halt, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("run1_halt_sticky", halt, 1'b1);
    check("run1_no_req_after_halt", 64'(n_after_halt), 64'd0);
    check("run1_fetch_count", 64'(fetch_q.size()), 64'd14);
    for (int i = 0; i < 14; i++) begin
      obs = (i < fetch_q.size()) ? fetch_q[i] : 32'hFFFF_FFFF;
      check($sformatf("run1_fetch[%0d]", i), obs, exp_fetch[i]);
    end
    check("run1_retire_count", 64'(lat_q.size()), 64'd13);
    for (int i = 0; i < 13; i++) begin
      obs = (i < lat_q.size()) ? 32'(lat_q[i]) : 32'hFFFF_FFFF;
      check($sformatf("run1_latency[%0d]", i), obs, 32'(exp_lat[i]));
    end
    check("run1_store_count", 64'(st_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < st_q.size()) begin
        check($sformatf("st[%0d]_addr", i), st_q[i].addr, exp_st_a[i]);
        check($sformatf("st[%0d]_data", i), st_q[i].data, exp_st_d[i]);
        check($sformatf("st[%0d]_req_cycles", i), st_q[i].len, 32'd4);
        check($sformatf("st[%0d]_stable", i), st_q[i].stable, 1'b1);
      end
    end

    // ---- run 2: misaligned LW traps without a data request ----
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("run2_rst_halt_clear", halt, 1'b0);
    check("run2_rst_pc", pc, RST_PC);
    load_instr(32'h100, 32'h00602283); // lw x5,6(x0)
    imem_wait = 2;
    bf = fetch_q.size(); bl = lat_q.size(); bd = n_dreq; bh = n_after_halt;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (halt === 1'b1) break;
      @(posedge clk); #1;
    end
    check("run2_halt", halt, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("run2_no_dmem_req", 64'(n_dreq - bd), 64'd0);
    check("run2_no_req_after_halt", 64'(n_after_halt - bh), 64'd0);
    check("run2_fetch_count", 64'(fetch_q.size() - bf), 64'd1);
    check("run2_no_retire", 64'(lat_q.size() - bl), 64'd0);

    // ---- run 3: reset while a fetch waits for ack ----
    @(negedge clk); rst_n = 1'b0;
    load_instr(32'h100, 32'h00500093);
    imem_wait = 0;
    @(negedge clk); rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (retire === 1'b1) begin got = 1'b1; break; end
    end
    check("run3_first_retire", got, 1'b1);
    imem_wait = 20;
    repeat (2) @(posedge clk);
    #1;
    check("run3_fetch_waiting_req", imem_req, 1'b1);
    check("run3_fetch_waiting_addr", imem_addr, 32'h104);
    check("run3_fetch_waiting_ack", imem_ack, 1'b0);
    rst_n = 1'b0;
    #1;
    check("run3_async_req_drop", imem_req, 1'b0);
    check("run3_async_pc", pc, RST_PC);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("run3_restart_req", imem_req, 1'b1);
    check("run3_restart_addr", imem_addr, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound in case the DUT stalls a wait loop indefinitely.
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
